alu_uart_sequencer: RTL and testbench
=====================================

Name: alu_uart_sequencer

Overview:
- Initiator side of the ALU operand/opcode interface.
- Receives three bytes from the UART receiver in order: operand A, operand B, opcode.
- Drives DATOA/DATOB/OPCODE into the combinational ALU, captures RESULT and hands it to the UART transmitter as one byte.
- Sits between the uart_rx/uart_tx pair and ALU in the board-level top.

Parameters:
SIZEDATA, 8, ALU operand/result width (must be <= SIZEBYTE)
SIZEOP, 6, ALU opcode width
SIZEBYTE, 8, UART byte width

Ports:
CLK  in  1  system clock, single clock domain
RESET  in  1  asynchronous, active-high reset
RX_DATA  in  SIZEBYTE  byte from UART receiver, valid when RX_DONE=1
RX_DONE  in  1  one-cycle pulse, new RX byte
TX_DATA  out  SIZEBYTE  byte to UART transmitter
TX_START  out  1  one-cycle pulse, start transmission of TX_DATA
TX_DONE  in  1  one-cycle pulse, transmitter finished byte
DATOA  out  SIZEDATA  ALU operand A (registered)
DATOB  out  SIZEDATA  ALU operand B (registered)
OPCODE  out  SIZEOP  ALU opcode (registered)
RESULT  in  SIZEDATA  ALU result, combinational from DATOA/DATOB/OPCODE
BUSY  out  1  high in every state except WAIT_A
OVERRUN  out  1  sticky: RX byte dropped
OPERR  out  1  sticky: illegal opcode byte received

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - State = WAIT_A.
  - DATOA, DATOB, OPCODE, TX_DATA = 0.
  - TX_START, BUSY, OVERRUN, OPERR = 0.
  - Reset mid-transaction discards partial operands and kills TX_START at once.
- States: WAIT_A -> WAIT_B -> WAIT_OP -> EXEC -> SEND -> WAIT_TX -> WAIT_A.
- WAIT_A: on RX_DONE, DATOA <= RX_DATA[SIZEDATA-1:0]; go to WAIT_B.
- WAIT_B: on RX_DONE, DATOB <= RX_DATA[SIZEDATA-1:0]; go to WAIT_OP.
- WAIT_OP: on RX_DONE, check RX_DATA[SIZEOP-1:0] against the legal set (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011).
  - Legal: OPCODE <= that value; go to EXEC.
  - Illegal: OPCODE unchanged; OPERR <= 1; go to WAIT_A; nothing transmitted.
- EXEC: one settle cycle for the ALU. At the closing edge, TX_DATA <= RESULT sign-extended to SIZEBYTE; go to SEND.
- SEND: TX_START = 1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on TX_DONE, go to WAIT_A.
- Latency: RX_DONE of the opcode byte in cycle n -> TX_START high in cycle n+2.
- DATOA/DATOB/OPCODE hold their values until overwritten by a later transaction; no output glitches between transactions.
- Upper RX_DATA bits beyond SIZEDATA/SIZEOP are ignored.
- RX_DONE in EXEC, SEND or WAIT_TX: byte dropped, OVERRUN <= 1, registers unchanged.
- Exception: RX_DONE in the same cycle as TX_DONE in WAIT_TX. The byte is accepted as the new DATOA, state goes directly to WAIT_B, and OVERRUN is unchanged.
- TX_DONE outside WAIT_TX: ignored.
- OVERRUN and OPERR clear only on RESET.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ADD, SUB, OR, XOR, AND, NOR, SRA, SRL (SIZEOP wide), also used by ALU;
  - state encoding constants (3-bit);
  - an is_legal_op function.
- No sub-module: a single FSM with datapath registers is natural. ALU is instantiated at top level, not inside this block.

Test Plan:
1. RX bytes 0x05, 0x03, 0x20 -> DATOA=5, DATOB=3, OPCODE=100000; TX_START one-cycle pulse 2 cycles after the third RX_DONE with TX_DATA=0x08; after TX_DONE, BUSY=0.
2. RX 0x03, 0x05, 0x22 (SUB) -> TX_DATA=0xFE. Then 0x80, 0x03, 0x03 (SRA) -> 0xF0. Then 0x80, 0x03, 0x02 (SRL) -> 0x10.
3. RX_DONE pulse in WAIT_TX, not coincident with TX_DONE -> OVERRUN=1, DATOA unchanged. RX_DONE coincident with TX_DONE (byte 0x11) -> DATOA=0x11, state WAIT_B, BUSY=1, OVERRUN unchanged.
4. RX 0x01, 0x02, 0x3F -> OPERR=1, no TX_START, OPCODE keeps its previous value, next three bytes start a fresh transaction.
5. RESET pulse after operand A accepted, and again during SEND -> all outputs 0 immediately without a clock edge; TX_START never reaches 2 cycles high; subsequent 0x0F, 0xF0, 0x25 (OR) -> TX_DATA=0xFF.
6. Back-to-back transactions with TX_DONE 10 cycles after TX_START, for all 8 opcodes with random A/B (B=3 for shifts) -> every TX_DATA matches the ALU golden model; no OVERRUN or OPERR.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, sequencer state encoding
// and the legal-opcode check used when the opcode byte arrives.
package alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] ADD = 6'b100000;
    localparam logic [OP_W-1:0] SUB = 6'b100010;
    localparam logic [OP_W-1:0] AND = 6'b100100;
    localparam logic [OP_W-1:0] OR  = 6'b100101;
    localparam logic [OP_W-1:0] XOR = 6'b100110;
    localparam logic [OP_W-1:0] NOR = 6'b100111;
    localparam logic [OP_W-1:0] SRL = 6'b000010;
    localparam logic [OP_W-1:0] SRA = 6'b000011;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op inside {ADD, SUB, AND, OR, XOR, NOR, SRL, SRA};
    endfunction

endpackage

// File: rtl/alu_uart_sequencer.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// presents them to the combinational ALU and sends RESULT back as a byte.
// Ports: CLK/RESET (async, active-high); RX_DATA/RX_DONE from uart_rx;
//        TX_DATA/TX_START/TX_DONE to uart_tx; DATOA/DATOB/OPCODE/RESULT
//        to/from the ALU; BUSY status; OVERRUN/OPERR sticky error flags.
module alu_uart_sequencer
    import alu_pkg::*;
#(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6,
    parameter int SIZEBYTE = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [SIZEBYTE-1:0] RX_DATA,
    input  logic                RX_DONE,
    output logic [SIZEBYTE-1:0] TX_DATA,
    output logic                TX_START,
    input  logic                TX_DONE,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    input  logic [SIZEDATA-1:0] RESULT,
    output logic                BUSY,
    output logic                OVERRUN,
    output logic                OPERR
);

    state_e              state_q, state_d;
    logic [SIZEDATA-1:0] data_a_q, data_a_d;
    logic [SIZEDATA-1:0] data_b_q, data_b_d;
    logic [SIZEOP-1:0]   opcode_q, opcode_d;
    logic [SIZEBYTE-1:0] tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                overrun_q, overrun_d;
    logic                operr_q, operr_d;
    logic                op_legal;

    assign op_legal = is_legal_op(OP_W'(RX_DATA[SIZEOP-1:0]));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
            operr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
            operr_q    <= operr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        overrun_d  = overrun_q;
        operr_d    = operr_q;

        unique case (state_q)
            ST_WAIT_A: begin
                if (RX_DONE) begin
                    data_a_d = RX_DATA[SIZEDATA-1:0];
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (RX_DONE) begin
                    data_b_d = RX_DATA[SIZEDATA-1:0];
                    state_d  = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (RX_DONE) begin
                    if (op_legal) begin
                        opcode_d = RX_DATA[SIZEOP-1:0];
                        state_d  = ST_EXEC;
                    end else begin
                        operr_d = 1'b1;
                        state_d = ST_WAIT_A;
                    end
                end
            end
            ST_EXEC: begin
                // ALU has settled on the registered operands by now.
                // Registering the start here makes TX_START a clean
                // flop output that is high only while in SEND.
                tx_data_d  = SIZEBYTE'($signed(RESULT));
                tx_start_d = 1'b1;
                state_d    = ST_SEND;
                if (RX_DONE) overrun_d = 1'b1;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
                if (RX_DONE) overrun_d = 1'b1;
            end
            ST_WAIT_TX: begin
                if (TX_DONE) begin
                    state_d = ST_WAIT_A;
                    // A byte landing with TX_DONE starts the next frame.
                    if (RX_DONE) begin
                        data_a_d = RX_DATA[SIZEDATA-1:0];
                        state_d  = ST_WAIT_B;
                    end
                end else if (RX_DONE) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_WAIT_A;
        endcase
    end

    assign DATOA    = data_a_q;
    assign DATOB    = data_b_q;
    assign OPCODE   = opcode_q;
    assign TX_DATA  = tx_data_q;
    assign TX_START = tx_start_q;
    assign BUSY     = (state_q != ST_WAIT_A);
    assign OVERRUN  = overrun_q;
    assign OPERR    = operr_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench for alu_uart_sequencer with a behavioural ALU
// and an arithmetic reference for every transmitted byte.
module tb_alu_uart_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] datoa;
    logic [7:0] datob;
    logic [5:0] opcode;
    logic [7:0] result;
    logic       busy;
    logic       overrun;
    logic       operr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_uart_sequencer #(
        .SIZEDATA(8),
        .SIZEOP  (6),
        .SIZEBYTE(8)
    ) dut (
        .CLK     (clk),
        .RESET   (rst),
        .RX_DATA (rx_data),
        .RX_DONE (rx_done),
        .TX_DATA (tx_data),
        .TX_START(tx_start),
        .TX_DONE (tx_done),
        .DATOA   (datoa),
        .DATOB   (datob),
        .OPCODE  (opcode),
        .RESULT  (result),
        .BUSY    (busy),
        .OVERRUN (overrun),
        .OPERR   (operr)
    );

    // Golden 8-bit ALU written with plain integer arithmetic.
    function automatic int golden(input int a, input int b, input int op);
        int sa;
        sa = (a > 127) ? a - 256 : a;
        case (op)
            'h20:    return (a + b) & 255;
            'h22:    return (a - b) & 255;
            'h24:    return a & b;
            'h25:    return a | b;
            'h26:    return a ^ b;
            'h27:    return (~(a | b)) & 255;
            'h02:    return (a >> b) & 255;
            'h03:    return (sa >>> b) & 255;
            default: return 0;
        endcase
    endfunction

    assign result = 8'(golden(int'(datoa), int'(datob), int'(opcode)));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"},   32'(datoa),    32'h0);
        chk({tag, "_b"},   32'(datob),    32'h0);
        chk({tag, "_op"},  32'(opcode),   32'h0);
        chk({tag, "_txd"}, 32'(tx_data),  32'h0);
        chk({tag, "_txs"}, 32'(tx_start), 32'h0);
        chk({tag, "_bsy"}, 32'(busy),     32'h0);
        chk({tag, "_ovr"}, 32'(overrun),  32'h0);
        chk({tag, "_oer"}, 32'(operr),    32'h0);
    endtask

    // Drive one RX byte for a single cycle; returns one negedge later.
    task automatic send(input logic [7:0] b, input logic with_txd);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        tx_done = with_txd;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
    endtask

    // Called right after the opcode byte: start pulse 2 cycles later.
    task automatic expect_tx(input string tag, input int exp);
        chk({tag, "_early"}, 32'(tx_start), 32'h0);
        @(negedge clk);
        chk({tag, "_start"}, 32'(tx_start), 32'h1);
        chk({tag, "_data"},  32'(tx_data),  32'(exp));
        chk({tag, "_busy"},  32'(busy),     32'h1);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(tx_start), 32'h0);
    endtask

    task automatic finish_tx(input string tag);
        repeat (8) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    task automatic run_txn(input string tag, input int a, input int b,
                           input int opb);
        int exp;
        exp = golden(a, b, opb & 'h3f);
        send(8'(a), 1'b0);
        send(8'(b), 1'b0);
        send(8'(opb), 1'b0);
        expect_tx(tag, exp);
        chk({tag, "_A"},  32'(datoa),  32'(a));
        chk({tag, "_B"},  32'(datob),  32'(b));
        chk({tag, "_OP"}, 32'(opcode), 32'(opb & 'h3f));
        finish_tx(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ops[8];
        ops = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h02, 'h03};
        rst     = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        tx_done = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic ADD
        run_txn("add", 'h05, 'h03, 'h20);

        // SUB, SRA, SRL
        run_txn("sub", 'h03, 'h05, 'h22);
        run_txn("sra", 'h80, 'h03, 'h03);
        run_txn("srl", 'h80, 'h03, 'h02);

        // Coincident RX_DONE/TX_DONE, then a plain overrun
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h20, 1'b0);
        expect_tx("ov1", 'h99);
        repeat (3) @(negedge clk);
        send(8'h11, 1'b1);
        chk("coin_a",   32'(datoa),   32'h11);
        chk("coin_bsy", 32'(busy),    32'h1);
        chk("coin_ovr", 32'(overrun), 32'h0);
        send(8'h22, 1'b0);
        send(8'h20, 1'b0);
        expect_tx("coin", 'h33);
        send(8'h77, 1'b0);
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_a",   32'(datoa),   32'h11);
        chk("ovr_b",   32'(datob),   32'h22);
        finish_tx("ovr");

        // Illegal opcode
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h3f, 1'b0);
        chk("operr",    32'(operr),  32'h1);
        chk("operr_op", 32'(opcode), 32'h20);
        chk("operr_bs", 32'(busy),   32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("operr_notx", 32'(tx_start), 32'h0);
        end
        run_txn("fresh", 'h09, 'h06, 'h26);
        chk("sticky_ovr", 32'(overrun), 32'h1);
        chk("sticky_oer", 32'(operr),   32'h1);

        // Reset after operand A
        send(8'h42, 1'b0);
        #2 rst = 1'b1;
        #1 chk_zero("rstA");
        #1 rst = 1'b0;
        // Reset during SEND
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h20, 1'b0);
        @(negedge clk);
        chk("send_start", 32'(tx_start), 32'h1);
        #2 rst = 1'b1;
        #1 chk_zero("rstS");
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstS_nostart", 32'(tx_start), 32'h0);
        run_txn("or", 'h0f, 'hf0, 'h25);

        // Back-to-back random transactions over all opcodes
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                int a, b, opb;
                a   = int'($urandom_range(0, 255));
                b   = (ops[i] < 'h10) ? 3 : int'($urandom_range(0, 255));
                opb = ops[i] | (int'($urandom_range(0, 3)) << 6);
                run_txn("rnd", a, b, opb);
            end
        end
        chk("end_ovr", 32'(overrun), 32'h0);
        chk("end_oer", 32'(operr),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
